// File: rtl/port_buffer.sv
// port_buffer: input-port flit FIFO with credit flow control and the
// requesting side of the switch-control handshake (o_h / i_ack_h / o_sender).
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

module port_buffer #(
    parameter int unsigned TAM_FLIT     = `TAM_FLIT,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_rx,
    input  logic [TAM_FLIT-1:0] i_data_in,
    output logic                o_credit_o,
    output logic                o_h,
    input  logic                i_ack_h,
    output logic                o_data_av,
    output logic [TAM_FLIT-1:0] o_data,
    input  logic                i_data_ack,
    output logic                o_sender
);

    localparam int unsigned PW = $clog2(BUFFER_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(BUFFER_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND_HDR,
        ST_SEND_SIZE,
        ST_SEND_PAY,
        ST_END
    } state_t;

    state_t              state_q, state_d;
    logic [TAM_FLIT-1:0] mem_q [BUFFER_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [TAM_FLIT-1:0] remaining_q, remaining_d;

    logic wr_en;
    logic rd_en;
    logic sending;
    logic not_empty;

    // Output decode from registered state and occupancy
    always_comb begin
        sending    = (state_q == ST_SEND_HDR) || (state_q == ST_SEND_SIZE) ||
                     (state_q == ST_SEND_PAY);
        not_empty  = (count_q != '0);
        o_credit_o = (count_q != FULL);
        o_h        = (state_q == ST_REQ);
        o_sender   = sending;
        o_data_av  = sending && not_empty;
        o_data     = mem_q[rd_ptr_q];
        wr_en      = i_rx && o_credit_o;
        rd_en      = o_data_av && i_data_ack;
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= i_data_in;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet FSM next-state: request, then stream header, size and payload
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (not_empty) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_ack_h) begin
                    state_d = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                if (rd_en) begin
                    state_d = ST_SEND_SIZE;
                end
            end
            ST_SEND_SIZE: begin
                if (rd_en) begin
                    remaining_d = o_data;
                    state_d     = (o_data == '0) ? ST_END : ST_SEND_PAY;
                end
            end
            ST_SEND_PAY: begin
                if (rd_en) begin
                    remaining_d = remaining_q - TAM_FLIT'(1);
                    if (remaining_q == TAM_FLIT'(1)) begin
                        state_d = ST_END;
                    end
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Packet FSM state and payload countdown registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_port_buffer.sv
// tb_port_buffer: directed self-checking bench for port_buffer.
module tb_port_buffer;

    logic        i_clk;
    logic        i_rst;
    logic        i_rx;
    logic [15:0] i_data_in;
    logic        o_credit_o;
    logic        o_h;
    logic        i_ack_h;
    logic        o_data_av;
    logic [15:0] o_data;
    logic        i_data_ack;
    logic        o_sender;

    int n_checks;
    int n_fail;

    port_buffer #(
        .TAM_FLIT    (16),
        .BUFFER_DEPTH(4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rx      (i_rx),
        .i_data_in (i_data_in),
        .o_credit_o(o_credit_o),
        .o_h       (o_h),
        .i_ack_h   (i_ack_h),
        .o_data_av (o_data_av),
        .o_data    (o_data),
        .i_data_ack(i_data_ack),
        .o_sender  (o_sender)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // advance one rising edge, then settle 1 ns past it
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rx       = 1'b0;
        i_data_in  = '0;
        i_ack_h    = 1'b0;
        i_data_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    logic [15:0] flits [0:5];
    logic [15:0] rd_data [0:7];
    int          rd_edge [0:7];
    logic        hs [0:19];
    logic        hh [0:19];
    int          nrd;
    int          idx;
    logic        wr;
    logic        did_read;
    int          rise1, fall1, rise2, fall2, hrise1, hrise2;
    int          gaps, drops;
    logic        started;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;

        // reset state
        check("rst_h", 32'(o_h), 32'd0);
        check("rst_sender", 32'(o_sender), 32'd0);
        check("rst_data_av", 32'(o_data_av), 32'd0);
        check("rst_credit", 32'(o_credit_o), 32'd1);
        check("rst_data", 32'(o_data), 32'h0);

        // stray ack_h in IDLE and data_ack on empty FIFO
        i_ack_h    = 1'b1;
        i_data_ack = 1'b1;
        tick();
        idle_inputs();
        check("stray_h", 32'(o_h), 32'd0);
        check("stray_sender", 32'(o_sender), 32'd0);
        check("stray_count", 32'(dut.count_q), 32'd0);
        tick();
        check("stray_h2", 32'(o_h), 32'd0);
        check("stray_credit", 32'(o_credit_o), 32'd1);

        // single packet, ack 3 edges after o_h rises, data_ack held high
        do_reset();
        flits[0] = 16'h0011; flits[1] = 16'h0002; flits[2] = 16'hAAAA; flits[3] = 16'hBBBB;
        i_data_ack = 1'b1;
        i_rx = 1'b1;
        i_data_in = flits[0];
        tick();
        check("sp_h_k", 32'(o_h), 32'd0);
        check("sp_data_k", 32'(o_data), 32'h0011);
        for (int i = 1; i < 4; i++) begin
            i_data_in = flits[i];
            tick();
            check("sp_h_wait", 32'(o_h), 32'd1);
        end
        i_rx    = 1'b0;
        i_ack_h = 1'b1;
        tick();
        i_ack_h = 1'b0;
        check("sp_h_after_ack", 32'(o_h), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("sp_sender", 32'(o_sender), 32'd1);
            check("sp_data_av", 32'(o_data_av), 32'd1);
            check("sp_data", 32'(o_data), 32'(flits[i]));
            tick();
        end
        check("sp_sender_end", 32'(o_sender), 32'd0);
        check("sp_av_end", 32'(o_data_av), 32'd0);
        tick();
        check("sp_h_idle", 32'(o_h), 32'd0);
        tick();
        check("sp_h_idle2", 32'(o_h), 32'd0);

        // full FIFO: six flits offered, four stored
        do_reset();
        flits[0] = 16'h0041; flits[1] = 16'h0002; flits[2] = 16'h00A1;
        flits[3] = 16'h00A2; flits[4] = 16'h00A3; flits[5] = 16'h00A4;
        for (int i = 0; i < 6; i++) begin
            i_rx = 1'b1;
            i_data_in = flits[i];
            tick();
            check("ff_credit", 32'(o_credit_o), 32'(i < 3));
        end
        i_rx = 1'b0;
        check("ff_count", 32'(dut.count_q), 32'd4);
        check("ff_head", 32'(o_data), 32'h0041);
        i_ack_h = 1'b1;
        tick();
        i_ack_h = 1'b0;
        check("ff_credit_pre_rd", 32'(o_credit_o), 32'd0);
        check("ff_av", 32'(o_data_av), 32'd1);
        i_data_ack = 1'b1;
        tick();
        check("ff_credit_rd", 32'(o_credit_o), 32'd1);
        check("ff_head2", 32'(o_data), 32'h0002);
        tick();
        check("ff_head3", 32'(o_data), 32'h00A1);
        tick();
        check("ff_head4", 32'(o_data), 32'h00A2);
        tick();
        i_data_ack = 1'b0;
        check("ff_count_end", 32'(dut.count_q), 32'd0);
        check("ff_sender_end", 32'(o_sender), 32'd0);

        // zero-size packet followed by a one-payload packet
        do_reset();
        flits[0] = 16'h0022; flits[1] = 16'h0000; flits[2] = 16'h0033;
        flits[3] = 16'h0001; flits[4] = 16'hCCCC;
        idx = 0; nrd = 0;
        for (int c = 0; c < 20; c++) begin
            hs[c] = o_sender;
            hh[c] = o_h;
            if (o_data_av && nrd < 8) begin
                rd_data[nrd] = o_data;
                rd_edge[nrd] = c + 1;
                nrd++;
            end
            i_rx       = o_credit_o && (idx < 5);
            i_data_in  = (idx < 5) ? flits[idx] : 16'h0;
            i_ack_h    = o_h;
            i_data_ack = 1'b1;
            wr = i_rx;
            tick();
            if (wr) idx++;
        end
        idle_inputs();
        rise1 = -1; fall1 = -1; rise2 = -1; fall2 = -1; hrise1 = -1; hrise2 = -1;
        for (int c = 1; c < 20; c++) begin
            if (hs[c] && !hs[c-1]) begin
                if (rise1 < 0) rise1 = c; else if (rise2 < 0) rise2 = c;
            end
            if (!hs[c] && hs[c-1]) begin
                if (fall1 < 0) fall1 = c; else if (fall2 < 0) fall2 = c;
            end
            if (hh[c] && !hh[c-1]) begin
                if (hrise1 < 0) hrise1 = c; else if (hrise2 < 0) hrise2 = c;
            end
        end
        check("zs_reads", 32'(nrd), 32'd5);
        for (int i = 0; i < 5; i++) check("zs_data", 32'(rd_data[i]), 32'(flits[i]));
        check("zs_run1", 32'(fall1 - rise1), 32'd2);
        check("zs_gap", 32'(rise2 - fall1 >= 1), 32'd1);
        check("zs_run2", 32'(fall2 - rise2), 32'd3);
        check("zs_rereq", 32'(hrise2), 32'(rd_edge[1] + 2));

        // underrun: payload every third cycle, N=3
        do_reset();
        nrd = 0; did_read = 1'b0; gaps = 0; drops = 0; started = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (did_read && nrd >= 2) check("ur_remaining", 32'(dut.remaining_q), 32'(5 - nrd));
            if (o_sender) started = 1'b1;
            if (started && nrd < 5 && !o_sender) drops++;
            if (o_sender && !o_data_av) gaps++;
            did_read = 1'b0;
            if (o_data_av && nrd < 8) begin
                rd_data[nrd] = o_data;
                nrd++;
                did_read = 1'b1;
            end
            i_rx = 1'b1;
            case (c)
                0:       i_data_in = 16'h0044;
                1:       i_data_in = 16'h0003;
                4:       i_data_in = 16'h0D01;
                7:       i_data_in = 16'h0D02;
                10:      i_data_in = 16'h0D03;
                default: begin i_rx = 1'b0; i_data_in = 16'h0; end
            endcase
            i_ack_h    = o_h;
            i_data_ack = 1'b1;
            tick();
        end
        idle_inputs();
        check("ur_reads", 32'(nrd), 32'd5);
        check("ur_gaps", 32'(gaps), 32'd4);
        check("ur_drops", 32'(drops), 32'd0);
        check("ur_p3", 32'(rd_data[4]), 32'h0D03);
        check("ur_rem_final", 32'(dut.remaining_q), 32'd0);

        // asynchronous reset during SEND_PAY
        do_reset();
        flits[0] = 16'h0055; flits[1] = 16'h0005; flits[2] = 16'h0E01; flits[3] = 16'h0E02;
        i_rx = 1'b1; i_data_in = flits[0]; tick();
        i_data_in = flits[1]; tick();
        i_data_in = flits[2]; i_ack_h = 1'b1; tick();
        i_ack_h = 1'b0; i_data_in = flits[3]; i_data_ack = 1'b1; tick();
        i_rx = 1'b0; tick();
        tick();
        check("mr_sender_pre", 32'(o_sender), 32'd1);
        check("mr_head_pre", 32'(o_data), 32'h0E02);
        #3;
        i_rst = 1'b1;
        #1;
        check("mr_sender", 32'(o_sender), 32'd0);
        check("mr_av", 32'(o_data_av), 32'd0);
        check("mr_h", 32'(o_h), 32'd0);
        check("mr_credit", 32'(o_credit_o), 32'd1);
        check("mr_data", 32'(o_data), 32'h0);
        tick();
        i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mr_no_emit", 32'(o_data_av), 32'd0);
        end
        check("mr_count", 32'(dut.count_q), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_buffer.md
# port_buffer

Input-port flit buffer for the Phoenix router, forming the requesting side of the switch-control handshake. It accepts flits from an upstream link under credit flow control and stores them in a FIFO. When a header reaches the FIFO head it raises a routing request (`o_h`) and waits for `i_ack_h`. It then streams the packet to the crossbar, holding `o_sender` high so switch control can release the output port when `o_sender` falls. One instance per router port (`NPORT` instances).

## Interface
- `TAM_FLIT`, default `` `TAM_FLIT `` (16): flit width in bits.
- `BUFFER_DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_rx`  in  1  upstream flit valid.
- `i_data_in`  in  TAM_FLIT  upstream flit.
- `o_credit_o`  out  1  buffer can accept a flit this cycle.
- `o_h`  out  1  routing request to switch control.
- `i_ack_h`  in  1  routing granted (single-cycle pulse from switch control).
- `o_data_av`  out  1  flit valid toward the crossbar.
- `o_data`  out  TAM_FLIT  flit at FIFO head.
- `i_data_ack`  in  1  downstream consumed `o_data` this cycle.
- `o_sender`  out  1  packet transfer in progress.

## Operation
- **Packet format:** flit 0 is the header (destination), flit 1 is the size N (payload flit count, full TAM_FLIT unsigned), then N payload flits. Total length is N+2. N=0 is legal.
- **FIFO**
  - Write when `i_rx & o_credit_o`; read when `o_data_av & i_data_ack`.
  - Occupancy counter `count` spans 0..BUFFER_DEPTH. Pointers wrap modulo BUFFER_DEPTH.
  - Simultaneous read and write leaves `count` unchanged and is legal at any occupancy where `o_credit_o`=1.
  - `o_credit_o` = (`count` != BUFFER_DEPTH), combinational from registered `count`. `i_rx` while `o_credit_o`=0 is ignored; no write and no pointer change.
  - `o_data` = mem[rd_ptr], combinational. Memory is cleared to 0 on reset.
- **FSM states:** IDLE, REQ, SEND_HDR, SEND_SIZE, SEND_PAY, END.
  - IDLE: if `count` != 0, go to REQ.
  - REQ: `o_h`=1. If `i_ack_h`=1, go to SEND_HDR; otherwise stay.
  - SEND_HDR: on a read (header consumed), go to SEND_SIZE.
  - SEND_SIZE: on a read, load `remaining` <= head flit. If the head flit is 0, go to END; otherwise go to SEND_PAY.
  - SEND_PAY: on a read, `remaining` <= `remaining`-1. If `remaining`==1, go to END.
  - END: go to IDLE unconditionally.
- **Output decode**
  - `o_h` = (state==REQ), registered decode.
  - `o_sender` = 1 in SEND_HDR, SEND_SIZE and SEND_PAY; 0 in IDLE, REQ and END.
  - `o_data_av` = (state in SEND_*) & (`count` != 0). It drops whenever the FIFO underruns mid-packet. No read and no `remaining` decrement occur while it is low.
- **Boundary conditions**
  - `i_ack_h` outside REQ is ignored.
  - `i_data_ack` while `o_data_av`=0 is ignored.
  - Flits of the next packet may be written while the current packet drains. The next header is not requested until the FSM passes through END and IDLE.

## Timing
- **Reset values:** `o_h`=0, `o_sender`=0, `o_data_av`=0, `o_credit_o`=1, `o_data`=0. State is IDLE, `count`=0, pointers 0, `remaining`=0.
- **Reset mid-packet:** the above apply immediately (asynchronously). Partial packet contents are discarded.
- **Write-to-visible latency:** a flit written at edge k appears on `o_data` after edge k. `o_h`=1 after edge k+1.
- **Ack handling:** `i_ack_h` sampled 1 at edge a gives `o_h`=0 and `o_sender`=1, with `o_data_av`=1 (header available) after edge a.
- **Throughput:** with `i_data_ack` held 1 and the FIFO never empty, one flit per cycle. A packet occupies N+2 cycles of `o_sender`=1.
- **Release:** the last read at edge e gives `o_sender`=0 after edge e (END). IDLE follows after e+1. Earliest re-request, `o_h`=1, is after edge e+2.
- **Credit:** `o_credit_o` reflects `count` after each edge. A read at edge r on a full FIFO gives `o_credit_o`=1 after edge r.

## Test plan
- **Reset mid-packet:** assert `i_rst` for 1 cycle during SEND_PAY, asynchronously between edges → `o_sender`, `o_data_av` and `o_h` go 0 and `o_credit_o` goes 1 immediately; no further flits are emitted.
- **Single packet:** send 0x0011, 0x0002, 0xAAAA, 0xBBBB; pulse `i_ack_h` 3 cycles after `o_h` rises; hold `i_data_ack`=1 → `o_h` high 1 cycle after header write until ack; `o_data` emits exactly 0x0011, 0x0002, 0xAAAA, 0xBBBB on consecutive cycles; `o_sender` high for exactly 4 cycles.
- **Full FIFO (DEPTH=4):** hold `i_data_ack`=0 and drive `i_rx`=1 with 6 distinct flits → exactly 4 stored and `o_credit_o`=0; one ack → `o_credit_o`=1 after that edge; flits 5 and 6 are not stored unless re-presented.
- **Zero-size packet back-to-back:** packet 0x0022/0x0000 followed by 0x0033/0x0001/0xCCCC, all prefilled → first `o_sender` high for 2 cycles, then low for at least 1 cycle; second `o_h` rises 2 edges after the first packet's last read.
- **Underrun:** upstream supplies payload every 3rd cycle, N=3 → `o_data_av` low in the gaps; `o_sender` stays high throughout; `remaining` reaches 0 only after the third payload read.
- **Stray inputs:** `i_ack_h` pulse in IDLE and `i_data_ack`=1 with an empty FIFO → no state change, `count` unchanged.
